// File: rtl/snes_pad_device.sv
// -----------------------------------------------------------------------------
// snes_pad_device
//
// Device (gamepad) end of the SNES pad serial link. The host raises dlatch to
// snapshot the buttons, then clocks 16 bits out on dclock. The host samples
// on dclock falling edges, and the pad advances to the next bit on each
// rising edge. Data on the wire is active-low (0 = pressed).
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-low reset
//   dlatch_i     host latch, asynchronous, high = load
//   dclock_i     host serial clock, asynchronous, idles high
//   buttons_i    button word, bit n = serial bit n, 1 = pressed
//   sdata_o      serial data to host, registered, 0 = pressed
//   frame_done_o one-cycle pulse when the 16th rising dclock edge is consumed
//   busy_o       high while loading or shifting
//
// Optional build macro SNES_PAD_DEVICE_TIMEOUT_EN: adds a shift-frame abort
// timer of TIMEOUT_US*1000/CLK_PER_NS cycles. When it expires, the pad
// returns to IDLE. Without the macro no timer exists, and SHIFT waits
// indefinitely.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no frame, sdata_o = 1
// LOAD  | latch high, shreg tracks buttons_i, bit 0 on the wire
// SHIFT | latch released, rising dclock edges advance the word
// DONE  | 16 bits sent, sdata_o = 0 like a real pad, clocks ignored
// -----------------------------------------------------------------------------
module snes_pad_device #(
  parameter int CLK_PER_NS  = 40,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_US  = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dlatch_i,
  input  logic        dclock_i,
  input  logic [15:0] buttons_i,
  output logic        sdata_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned TO_CYCLES = (TIMEOUT_US * 1000) / CLK_PER_NS;

  // Synchronisers. Reset values match the idle pins (latch low, clock high),
  // so that leaving reset cannot look like an edge.
  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_hist_q;
  logic                   clk_hist_q;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_fall;
  logic                   clk_rise;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_fall = latch_hist_q & ~latch_s;
  assign clk_rise   = clk_s & ~clk_hist_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      latch_hist_q <= 1'b0;
      clk_hist_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], dlatch_i};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], dclock_i};
      latch_hist_q <= latch_s;
      clk_hist_q   <= clk_s;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        sdata_q, sdata_d;
  logic        frame_done_q, frame_done_d;
  logic        timeout_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      sdata_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      sdata_q      <= sdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    frame_done_d = 1'b0;

    // A high latch wins from any state, even over a clock edge in the same
    // cycle. Reloading every cycle means the snapshot is the last
    // buttons_i value seen before the latch drops.
    if (latch_s) begin
      state_d  = S_LOAD;
      shreg_d  = buttons_i;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (latch_fall) begin
            state_d  = S_SHIFT;
            bitcnt_d = '0;
          end
        end
        S_SHIFT: begin
          if (clk_rise) begin
            shreg_d  = shreg_q >> 1;
            // Saturates at 16 on DONE entry and is never stepped again.
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd15) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end
          end else if (timeout_hit) begin
            state_d  = S_IDLE;
            bitcnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    // The output is computed from the next state so that a pin edge reaches
    // sdata_o after SYNC_STAGES+1 clocks.
    case (state_d)
      S_LOAD, S_SHIFT: sdata_d = ~shreg_d[0];
      S_DONE:          sdata_d = 1'b0;
      default:         sdata_d = 1'b1;
    endcase
  end

`ifdef SNES_PAD_DEVICE_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Down-counter, reloaded on SHIFT entry and on every rising dclock.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d == S_SHIFT && (state_q != S_SHIFT || clk_rise)) begin
      to_cnt_d = TO_W'(TO_CYCLES - 1);
    end else if (state_q == S_SHIFT && to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end
  end

  assign timeout_hit = (to_cnt_q == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign sdata_o      = sdata_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_snes_pad_device.sv
`timescale 1ns/1ps
module tb_snes_pad_device;

  localparam int TO_US = 20;

  logic        clk_i     = 1'b0;
  logic        rst_i     = 1'b0;
  logic        dlatch_i  = 1'b0;
  logic        dclock_i  = 1'b1;
  logic [15:0] buttons_i = '0;
  logic        sdata_o;
  logic        frame_done_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #20 clk_i = ~clk_i;

  snes_pad_device #(
    .CLK_PER_NS (40),
    .SYNC_STAGES(2),
    .TIMEOUT_US (TO_US)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dlatch_i    (dlatch_i),
    .dclock_i    (dclock_i),
    .buttons_i   (buttons_i),
    .sdata_o     (sdata_o),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o)
  );

  always @(negedge clk_i) begin
    if (frame_done_o === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what a host reads on each falling edge is the inverse
  // of the snapshot bit, and the line level after n rising edges is the
  // next bit, or 0 once all 16 bits have gone.
  function automatic logic [15:0] model_stream(input logic [15:0] snap);
    logic [15:0] s;
    for (int i = 0; i < 16; i++) s[i] = (snap[i] == 1'b1) ? 1'b0 : 1'b1;
    return s;
  endfunction

  function automatic logic model_level(input logic [15:0] snap, input int n_rises);
    if (n_rises >= 16) return 1'b0;
    return (snap[n_rises] == 1'b1) ? 1'b0 : 1'b1;
  endfunction

  function automatic int jit();
    return int'($urandom_range(0, 39));
  endfunction

  // One host transaction: latch pulse, then nclk clock pulses. The host
  // samples sdata just before each falling edge. buttons_i is switched to
  // btn_mid once shifting has begun.
  task automatic host_frame(input logic [15:0] btn, input logic [15:0] btn_mid,
                            input int hp, input int nclk, output logic [15:0] got);
    got       = '1;
    buttons_i = btn;
    dlatch_i  = 1'b1;
    #(2 * hp + jit());
    dlatch_i  = 1'b0;
    #(hp + jit());
    for (int i = 0; i < nclk; i++) begin
      got[i] = sdata_o;
      if (i == 0) buttons_i = btn_mid;
      dclock_i = 1'b0;
      #(hp + jit());
      dclock_i = 1'b1;
      #(hp + jit());
    end
  endtask

  task automatic pulse_clocks(input int n, input int hp, output logic [15:0] seen);
    seen = '1;
    for (int i = 0; i < n; i++) begin
      seen[i]  = sdata_o;
      dclock_i = 1'b0;
      #(hp + jit());
      dclock_i = 1'b1;
      #(hp + jit());
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    logic [15:0] seen;
    logic [15:0] btn;
    int          d0;
    int          hp;

    // Reset
    repeat (4) @(posedge clk_i);
    #1;
    chk("rst_sdata", 32'(sdata_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("post_rst_sdata", 32'(sdata_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Nominal frame at real pad timing
    d0 = done_cnt;
    host_frame(16'h0101, 16'h0101, 6000, 16, got);
    chk("nom_bits", 32'(got), 32'(model_stream(16'h0101)));
    chk("nom_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("nom_sdata_after", 32'(sdata_o), 32'(model_level(16'h0101, 16)));
    chk("nom_busy_after", 32'(busy_o), 32'd0);
    pulse_clocks(3, 400, seen);
    chk("done_ignores_clk", 32'(sdata_o), 32'd0);
    chk("done_no_repulse", 32'(done_cnt - d0), 32'd1);

    // Randomised frames with jittered host timing
    for (int r = 0; r < 6; r++) begin
      btn = 16'($urandom);
      hp  = int'($urandom_range(300, 800));
      d0  = done_cnt;
      host_frame(btn, 16'($urandom), hp, 16, got);
      chk("rnd_bits", 32'(got), 32'(model_stream(btn)));
      chk("rnd_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("rnd_sdata_after", 32'(sdata_o), 32'(model_level(btn, 16)));
      chk("rnd_busy_after", 32'(busy_o), 32'd0);
    end

    // Snapshot isolation
    d0 = done_cnt;
    host_frame(16'h0800, 16'hFFFF, 500, 16, got);
    chk("snap_bits", 32'(got), 32'(model_stream(16'h0800)));
    chk("snap_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Latch re-asserted mid-frame
    d0  = done_cnt;
    btn = 16'($urandom);
    host_frame(btn, btn, 400, 5, got);
    chk("mid_partial", 32'(got[4:0]), 32'(model_stream(btn) & 16'h001F));
    chk("mid_level", 32'(sdata_o), 32'(model_level(btn, 5)));
    host_frame(16'h0002, 16'h0002, 400, 16, got);
    chk("mid_new_bits", 32'(got), 32'(model_stream(16'h0002)));
    chk("mid_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset mid-shift
    d0 = done_cnt;
    host_frame(16'h00F0, 16'h00F0, 400, 8, got);
    chk("rmid_level_pre", 32'(sdata_o), 32'(model_level(16'h00F0, 8)));
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rmid_sdata", 32'(sdata_o), 32'd1);
    chk("rmid_busy", 32'(busy_o), 32'd0);
    pulse_clocks(8, 400, seen);
    chk("rmid_clk_no_latch", 32'(seen[7:0]), 32'hFF);
    chk("rmid_sdata_end", 32'(sdata_o), 32'd1);
    chk("rmid_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Latency: rising dclock to sdata change in exactly 3 clk cycles
    @(negedge clk_i);
    buttons_i = 16'h0001;
    dlatch_i  = 1'b1;
    repeat (10) @(negedge clk_i);
    dlatch_i  = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("lat_bit0", 32'(sdata_o), 32'(model_level(16'h0001, 0)));
    dclock_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("lat_fall_ignored", 32'(sdata_o), 32'(model_level(16'h0001, 0)));
    dclock_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("lat_before_3", 32'(sdata_o), 32'(model_level(16'h0001, 0)));
    @(posedge clk_i);
    #1;
    chk("lat_at_3", 32'(sdata_o), 32'(model_level(16'h0001, 1)));

    // Host goes silent mid-frame
    d0 = done_cnt;
    host_frame(16'h0008, 16'h0008, 400, 3, got);
    chk("to_bits", 32'(got[2:0]), 32'(model_stream(16'h0008) & 16'h0007));
    repeat (700) @(negedge clk_i);
`ifdef SNES_PAD_DEVICE_TIMEOUT_EN
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_sdata", 32'(sdata_o), 32'd1);
`else
    chk("to_busy", 32'(busy_o), 32'd1);
    chk("to_sdata", 32'(sdata_o), 32'(model_level(16'h0008, 3)));
`endif
    chk("to_done_cnt", 32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
